// File: rtl/clock_mode_controller_if.sv
// Button, tick and mode-output bundle between the clock top level and its controller.
interface clock_mode_controller_if;
  logic       tick_1hz;
  logic       b1;
  logic       b2;
  logic       b3;
  logic [3:0] state;
  logic [2:0] city;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       mode_chg;

  modport master (
    output tick_1hz, b1, b2, b3,
    input  state, city, inc_pulse, dec_pulse, mode_chg
  );

  modport slave (
    input  tick_1hz, b1, b2, b3,
    output state, city, inc_pulse, dec_pulse, mode_chg
  );
endinterface

// File: rtl/clock_mode_controller.sv
// Mode sequencer: conditions three push-buttons, steps the display mode,
// routes inc/dec strobes, owns the world-clock city index and falls back
// to the home clock after an inactivity timeout.
module clock_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_SEC     = 30,
  parameter int NUM_CITIES      = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  clock_mode_controller_if.slave  cmc
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [2:0] CITY_MAX = 3'(NUM_CITIES - 1);

  typedef enum logic [3:0] {
    CLOCK     = 4'd0,
    SET_TIME  = 4'd1,
    ALARM     = 4'd2,
    STOPWATCH = 4'd3,
    WORLD     = 4'd8
  } state_t;

  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_lvl;
  logic [2:0]    r_pb;
  logic [CW-1:0] r_cnt [3];

  state_t        r_state;
  state_t        w_next;
  logic          w_legal;
  logic          w_tmo_en;
  logic [2:0]    r_city;
  logic [TW-1:0] r_tmo;
  logic          r_inc;
  logic          r_dec;
  logic          r_mode_chg;

  // Index 0 = b1 (inc/next), 1 = b2 (dec/prev), 2 = b3 (mode).
  assign w_raw = {cmc.b3, cmc.b2, cmc.b1};

  // Synchronise each button, debounce it and emit a one-cycle press pulse on the debounced rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_lvl   <= 3'b000;
      r_pb    <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_cnt[i] <= {CW{1'b0}};
          r_pb[i]  <= 1'b0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
          // Input has disagreed long enough: accept the new level.
          r_lvl[i] <= ~r_lvl[i];
          r_cnt[i] <= {CW{1'b0}};
          r_pb[i]  <= ~r_lvl[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
          r_pb[i]  <= 1'b0;
        end
      end
    end
  end

  // Next mode in the advance ring, legality of the current code, and whether it can time out.
  always_comb begin
    w_next   = CLOCK;
    w_legal  = 1'b1;
    w_tmo_en = 1'b0;
    case (r_state)
      CLOCK:     begin w_next = SET_TIME;  w_legal = 1'b1; w_tmo_en = 1'b0; end
      SET_TIME:  begin w_next = ALARM;     w_legal = 1'b1; w_tmo_en = 1'b1; end
      ALARM:     begin w_next = STOPWATCH; w_legal = 1'b1; w_tmo_en = 1'b1; end
      STOPWATCH: begin w_next = WORLD;     w_legal = 1'b1; w_tmo_en = 1'b0; end
      WORLD:     begin w_next = CLOCK;     w_legal = 1'b1; w_tmo_en = 1'b1; end
      default:   begin w_next = CLOCK;     w_legal = 1'b0; w_tmo_en = 1'b0; end
    endcase
  end

  // Mode FSM with pulse routing, city index and inactivity timeout; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= CLOCK;
      r_city     <= 3'd0;
      r_tmo      <= {TW{1'b0}};
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_mode_chg <= 1'b0;
    end else begin
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_mode_chg <= 1'b0;
      if (!w_legal) begin
        r_state    <= CLOCK;
        r_mode_chg <= 1'b1;
        r_tmo      <= {TW{1'b0}};
      end else if (r_pb[2]) begin
        // Mode advance takes priority; any coincident inc/dec press is dropped.
        r_state    <= w_next;
        r_mode_chg <= 1'b1;
        r_tmo      <= {TW{1'b0}};
      end else if (r_pb[0] || r_pb[1]) begin
        r_tmo <= {TW{1'b0}};
        // Both pressed together is ambiguous, so neither acts.
        if (r_pb[0] != r_pb[1]) begin
          if (r_state == WORLD) begin
            if (r_pb[0]) begin
              r_city <= (r_city == CITY_MAX) ? 3'd0 : r_city + 3'd1;
            end else begin
              r_city <= (r_city == 3'd0) ? CITY_MAX : r_city - 3'd1;
            end
          end else if (r_state != CLOCK) begin
            r_inc <= r_pb[0];
            r_dec <= r_pb[1];
          end
        end
      end else if (cmc.tick_1hz && w_tmo_en) begin
        if (r_tmo == TW'(TIMEOUT_SEC - 1)) begin
          r_state    <= CLOCK;
          r_mode_chg <= 1'b1;
          r_tmo      <= {TW{1'b0}};
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else if (!w_tmo_en) begin
        r_tmo <= {TW{1'b0}};
      end
    end
  end

  assign cmc.state     = r_state;
  assign cmc.city      = r_city;
  assign cmc.inc_pulse = r_inc;
  assign cmc.dec_pulse = r_dec;
  assign cmc.mode_chg  = r_mode_chg;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Self-checking bench for clock_mode_controller: directed test-plan scenarios
// followed by random button/tick traffic, all compared against a
// behavioural model of the button timing and mode rules.
module tb_clock_mode_controller;

  localparam int D    = 16;
  localparam int TMO  = 30;
  localparam int NC   = 5;

  logic       clk;
  logic       reset;
  logic [2:0] raw;
  logic       tick;

  int n_vec;
  int n_err;
  int inc_seen;
  int chg_seen;

  clock_mode_controller_if cmc();

  assign cmc.b1       = raw[0];
  assign cmc.b2       = raw[1];
  assign cmc.b3       = raw[2];
  assign cmc.tick_1hz = tick;

  clock_mode_controller #(
    .DEBOUNCE_CYCLES (D),
    .TIMEOUT_SEC     (TMO),
    .NUM_CITIES      (NC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cmc   (cmc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // hist[b][m] = raw level of button b seen m+1 edges ago (index 1 is what the
  // synchroniser presents now). The debounced level flips once the last D+1
  // synchronised samples all disagree with it.
  bit hist [3][D+2];
  bit lvl  [3];
  bit pbm  [3];
  int order [5] = '{0, 1, 2, 3, 8};
  int idx;
  int city_m;
  int secs;
  bit inc_m, dec_m, chg_m;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < D + 2; j++) hist[b][j] = 1'b0;
      lvl[b] = 1'b0;
      pbm[b] = 1'b0;
    end
    idx = 0; city_m = 0; secs = 0;
    inc_m = 1'b0; dec_m = 1'b0; chg_m = 1'b0;
  endtask

  task automatic model_edge();
    bit npb [3];
    bit tog;
    int mode;
    bit can_tmo;
    for (int b = 0; b < 3; b++) begin
      tog = 1'b1;
      for (int j = 1; j <= D + 1; j++) if (hist[b][j] == lvl[b]) tog = 1'b0;
      npb[b] = tog && !lvl[b];
      if (tog) lvl[b] = !lvl[b];
      for (int j = D + 1; j >= 1; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = raw[b];
    end
    mode    = order[idx];
    can_tmo = (mode == 1) || (mode == 2) || (mode == 8);
    inc_m = 1'b0; dec_m = 1'b0; chg_m = 1'b0;
    if (pbm[2]) begin
      idx = (idx + 1) % 5; chg_m = 1'b1; secs = 0;
    end else if (pbm[0] || pbm[1]) begin
      secs = 0;
      if (pbm[0] != pbm[1]) begin
        if (mode == 8) city_m = pbm[0] ? (city_m + 1) % NC : (city_m + NC - 1) % NC;
        else if (mode != 0) begin inc_m = pbm[0]; dec_m = pbm[1]; end
      end
    end else if (tick && can_tmo) begin
      secs++;
      if (secs == TMO) begin idx = 0; chg_m = 1'b1; secs = 0; end
    end else if (!can_tmo) begin
      secs = 0;
    end
    for (int b = 0; b < 3; b++) pbm[b] = npb[b];
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("state", 32'(cmc.state), 32'(order[idx]));
    check_eq("city", 32'(cmc.city), 32'(city_m));
    check_eq("inc_pulse", 32'(cmc.inc_pulse), 32'(inc_m));
    check_eq("dec_pulse", 32'(cmc.dec_pulse), 32'(dec_m));
    check_eq("mode_chg", 32'(cmc.mode_chg), 32'(chg_m));
    check_eq("city_range", 32'(cmc.city < 3'(NC)), 32'd1);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    inc_seen += int'(cmc.inc_pulse);
    chg_seen += int'(cmc.mode_chg);
    check_outputs();
  endtask

  task automatic press(input int b, input int hold);
    raw[b] = 1'b1;
    repeat (hold) cycle();
    raw[b] = 1'b0;
    repeat (40) cycle();
  endtask

  // Press a button and measure edges from first sample to the state change.
  task automatic press_timed(input int b);
    logic [3:0] prev;
    int n;
    prev = cmc.state;
    n = 0;
    raw[b] = 1'b1;
    do begin
      cycle();
      n++;
    end while (cmc.state == prev && n < 100);
    check_eq("pb_latency", 32'(n - 1), 32'(D + 3));
    if (n < 40) repeat (40 - n) cycle();
    raw[b] = 1'b0;
    repeat (40) cycle();
  endtask

  task automatic give_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      repeat (3) cycle();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (3) cycle();
    reset = 1'b1;
  endtask

  initial begin : stim
    int city_exp [6] = '{1, 2, 3, 4, 0, 1};
    int rem [3];
    n_vec = 0; n_err = 0; inc_seen = 0; chg_seen = 0;
    raw = 3'b000; tick = 1'b0; reset = 1'b1;
    model_reset();

    apply_reset();
    check_eq("reset_state", 32'(cmc.state), 32'd0);
    repeat (5) cycle();

    // Three mode advances with latency and one mode_chg each.
    chg_seen = 0;
    press_timed(2);
    press_timed(2);
    press_timed(2);
    check_eq("after_3_pb3", 32'(cmc.state), 32'd3);
    check_eq("mode_chg_count", 32'(chg_seen), 32'd3);

    // Back round to SET_TIME, then glitch + real b1 press.
    press(2, 40); press(2, 40); press(2, 40);
    check_eq("at_set_time", 32'(cmc.state), 32'd1);
    inc_seen = 0;
    raw[0] = 1'b1; repeat (10) cycle(); raw[0] = 1'b0; repeat (30) cycle();
    check_eq("glitch_inc", 32'(inc_seen), 32'd0);
    press(0, 40);
    check_eq("press_inc", 32'(inc_seen), 32'd1);
    check_eq("city_hold", 32'(cmc.city), 32'd0);

    // WORLD: city stepping and wrap both ways.
    press(2, 40); press(2, 40); press(2, 40);
    check_eq("at_world", 32'(cmc.state), 32'd8);
    for (int k = 0; k < 6; k++) begin
      press(0, 40);
      check_eq("city_step", 32'(cmc.city), 32'(city_exp[k]));
    end
    repeat (4) press(0, 40);
    check_eq("city_zero", 32'(cmc.city), 32'd0);
    press(1, 40);
    check_eq("city_wrap_down", 32'(cmc.city), 32'd4);

    // Timeout in SET_TIME.
    press(2, 40); press(2, 40);
    check_eq("timeout_start", 32'(cmc.state), 32'd1);
    chg_seen = 0;
    give_ticks(29);
    check_eq("tick29_state", 32'(cmc.state), 32'd1);
    give_ticks(1);
    check_eq("timeout_state", 32'(cmc.state), 32'd0);
    check_eq("timeout_chg", 32'(chg_seen), 32'd1);

    // Button activity after tick 29 restarts the count.
    press(2, 40);
    give_ticks(29);
    press(1, 40);
    give_ticks(29);
    check_eq("restart_hold", 32'(cmc.state), 32'd1);
    give_ticks(1);
    check_eq("restart_timeout", 32'(cmc.state), 32'd0);

    // b3 and b1 together in STOPWATCH.
    press(2, 40); press(2, 40); press(2, 40);
    check_eq("at_stopwatch", 32'(cmc.state), 32'd3);
    inc_seen = 0;
    raw = 3'b101; repeat (40) cycle(); raw = 3'b000; repeat (40) cycle();
    check_eq("simul_state", 32'(cmc.state), 32'd8);
    check_eq("simul_inc", 32'(inc_seen), 32'd0);
    check_eq("simul_city", 32'(cmc.city), 32'd4);

    // Reset midway through a b1 debounce in WORLD with city 3.
    press(0, 40); press(0, 40); press(0, 40); press(0, 40);
    check_eq("city_three", 32'(cmc.city), 32'd3);
    raw[0] = 1'b1;
    repeat (8) cycle();
    apply_reset();
    check_eq("rst_city", 32'(cmc.city), 32'd0);
    check_eq("rst_state", 32'(cmc.state), 32'd0);
    inc_seen = 0; chg_seen = 0;
    repeat (5) cycle();
    check_eq("rst_no_pulse", 32'(inc_seen + chg_seen), 32'd0);
    raw[0] = 1'b0;
    repeat (40) cycle();

    // Random traffic against the model.
    for (int b = 0; b < 3; b++) rem[b] = 0;
    repeat (4000) begin
      tick = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          raw[b] = ~raw[b];
          rem[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12))
                                                 : int'($urandom_range(20, 60));
        end
        rem[b]--;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Top-level mode sequencer for the Spartan-3 clock.
- Debounces and edge-detects the three raw push-buttons. Generates the 4-bit mode code (`state`) consumed by the time-set, alarm, stopwatch and world-clock datapaths.
- Routes single-cycle increment/decrement pulses to the active mode.
- Owns the world-clock city index directly, with clean modulo wrap.
- Returns to the home clock display after an inactivity timeout.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before the debounced level changes (16 for simulation, 50000 on board)
- TIMEOUT_SEC, 30, tick_1hz pulses without any button pulse before an edit mode falls back to CLOCK
- NUM_CITIES, 5, number of world-clock cities; city index range 0..NUM_CITIES-1 (NUM_CITIES must be between 2 and 8)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tick_1hz  input  1  one-clk-wide pulse per second from the timebase
- b1  input  1  raw button, increment/next
- b2  input  1  raw button, decrement/previous
- b3  input  1  raw button, mode advance
- state  output  4  current mode code
- city  output  3  world-clock city index
- inc_pulse  output  1  one-cycle increment strobe to the active datapath
- dec_pulse  output  1  one-cycle decrement strobe to the active datapath
- mode_chg  output  1  one-cycle strobe in the cycle after state changes

Behaviour:
- Reset (asynchronous, active-low) values:
  - state=4'd0 (CLOCK), city=0, inc_pulse=0, dec_pulse=0, mode_chg=0
  - all synchronizers, debounce counters, debounced levels and the timeout counter cleared to 0
  - Reset mid-debounce or mid-timeout discards all progress; no pulse is emitted on release of reset.
- Per-button conditioning (identical instance for b1/b2/b3):
  - 2-FF synchronizer, then debounce counter.
  - The counter increments while the synchronized input differs from the debounced level, and clears when they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Press pulse (pb1/pb2/pb3) is one cycle, on the debounced 0->1 transition only. Release produces nothing.
  - A raw glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
  - Latency: a raw rise held stable produces its pulse DEBOUNCE_CYCLES+3 clk edges after the raw rise is first sampled.
- Mode FSM (state encoding): CLOCK=0, SET_TIME=1, ALARM=2, STOPWATCH=3, WORLD=8.
  - pb3 advances CLOCK->SET_TIME->ALARM->STOPWATCH->WORLD->CLOCK.
  - No other codes are ever produced. An illegal state, which is unreachable, recovers to CLOCK on the next edge.
- Pulse routing, evaluated on the same edge as the press pulse, with outputs registered (1 cycle after pbX):
  - SET_TIME, ALARM, STOPWATCH: pb1 -> inc_pulse, pb2 -> dec_pulse.
  - WORLD: pb1 -> city+1, with city=NUM_CITIES-1 wrapping to 0 in a single edge (no out-of-range value is ever visible). pb2 -> city-1, with 0 wrapping to NUM_CITIES-1. inc_pulse/dec_pulse stay 0.
  - CLOCK: pb1/pb2 ignored.
- city is held in every mode other than WORLD, and retained across timeout and mode cycling.
- Simultaneous events:
  - pb3 with pb1 or pb2 in the same cycle: the mode advances; pb1/pb2 are dropped.
  - pb1 and pb2 together: both dropped, and no city change.
- Timeout:
  - Active in SET_TIME, ALARM and WORLD only. CLOCK and STOPWATCH never time out.
  - The counter increments on tick_1hz and clears on any pb1/pb2/pb3 or on any state change.
  - When the counter reaches TIMEOUT_SEC, state->CLOCK on that edge, mode_chg pulses the next cycle, and the counter clears.
  - tick_1hz coincident with a button pulse: the clear wins.
- mode_chg asserts for exactly one cycle after every state change, whether caused by pb3 or by timeout.

Test Plan:
- Reset, then 3 pb3 presses (each held 40 clks) -> state 0->1->2->3; each step lands DEBOUNCE_CYCLES+3 edges after the raw rise, with one mode_chg per step.
- b1 glitch of 10 clks, then b1 held 40 clks, in SET_TIME -> exactly one inc_pulse, none for the glitch; no city change.
- WORLD mode, 6 b1 presses -> city 1,2,3,4,0,1. Then from city=0, one b2 press -> city=4; city is never observed >=5.
- SET_TIME, no buttons, 30 tick_1hz pulses -> state=0 after the 30th tick, with one mode_chg. Repeat with a b2 press after tick 29 -> no timeout until 30 further ticks.
- b3 and b1 rising in the same clk while in STOPWATCH -> state=8, no inc_pulse, city unchanged.
- Reset asserted midway through a b1 debounce in WORLD with city=3 -> city=0 and state=0 immediately; no pulse after reset releases while b1 stays high.
